// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
//   Shared types and the data-side address map for data_bus_interconnect.
//   - bus_state_t : interconnect FSM states
//   - SLV_BASE / SLV_SIZE : byte-address windows. Slots 0..3 are RAM, TIMER,
//     TMP and GPIO. Slots 4..7 are spare windows, so N_SLV can grow to 8
//     without touching the decoder.
//   - ERR_RDATA : read data returned with every failed access
//   - idx_width() : width of a slave index for a given slave count
// -----------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bus_state_t;

  localparam int N_SLV_MAX = 8;

  localparam logic [31:0] SLV_BASE [N_SLV_MAX] = '{
    32'h0000_1000,  // RAM
    32'h0000_2000,  // TIMER
    32'h0000_2100,  // TMP
    32'h0000_2200,  // GPIO
    32'h0000_2300,
    32'h0000_2400,
    32'h0000_2500,
    32'h0000_2600
  };

  localparam logic [31:0] SLV_SIZE [N_SLV_MAX] = '{
    32'h0000_1000,
    32'h0000_0100,
    32'h0000_0100,
    32'h0000_0100,
    32'h0000_0100,
    32'h0000_0100,
    32'h0000_0100,
    32'h0000_0100
  };

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// -----------------------------------------------------------------------------
// bus_addr_decoder
//   Combinational decode of a byte address against the first N_SLV windows
//   of the bus_pkg address map.
//   Ports:
//     addr    in   XLEN    byte address from the core
//     hit     out  1       address falls inside at least one window
//     sel     out  N_SLV   one-hot select of the winning window (0 on miss)
//     index   out  IDX_W   binary index of the winning window
//     offset  out  XLEN    word offset inside the window: (addr - base) >> 2
//   When windows overlap, the lowest index wins.
// -----------------------------------------------------------------------------
import bus_pkg::*;

module bus_addr_decoder #(
  parameter int XLEN  = 32,
  parameter int N_SLV = 4,
  parameter int IDX_W = idx_width(N_SLV)
) (
  input  logic [XLEN-1:0]  addr,
  output logic             hit,
  output logic [N_SLV-1:0] sel,
  output logic [IDX_W-1:0] index,
  output logic [XLEN-1:0]  offset
);

  logic [N_SLV-1:0] hit_vec;
  logic [XLEN-1:0]  base;

  // One extra bit on the window limit, so a window that ends at the top
  // of the address space cannot wrap around.
  for (genvar gi = 0; gi < N_SLV; gi++) begin : g_win
    localparam logic [XLEN:0] WIN_LO = (XLEN+1)'(SLV_BASE[gi]);
    localparam logic [XLEN:0] WIN_HI = WIN_LO + (XLEN+1)'(SLV_SIZE[gi]);
    assign hit_vec[gi] = ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
  end

  assign hit = |hit_vec;

  // Isolate the lowest set bit. This gives lowest-index-wins priority.
  assign sel = hit_vec & ~(hit_vec - N_SLV'(1));

  // Walk from high to low, so the last assignment is the lowest hit.
  always_comb begin
    index = '0;
    base  = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        index = IDX_W'(i);
        base  = XLEN'(SLV_BASE[i]);
      end
    end
  end

  assign offset = (addr - base) >> 2;

endmodule

// File: rtl/data_bus_interconnect.sv
// -----------------------------------------------------------------------------
// data_bus_interconnect
//   Data-side bus between the core and N_SLV memory-mapped slaves. It accepts
//   one request at a time and decodes it to a slave window. It holds a
//   registered select until that slave acknowledges or the watchdog fires,
//   then returns a one-cycle ready pulse with an error qualifier.
//   Ports:
//     clk_i        in   1           core clock
//     rst_ni       in   1           asynchronous active-low reset
//     cpu_req_i    in   1           request, held by the core until ready
//     cpu_we_i     in   1           1 = write, 0 = read
//     cpu_addr_i   in   XLEN        byte address
//     cpu_wdata_i  in   XLEN        write data
//     cpu_rdata_o  out  XLEN        read data, valid with ready, held after
//     cpu_ready_o  out  1           one-cycle completion pulse
//     cpu_err_o    out  1           access failed (qualifies ready)
//     slv_sel_o    out  N_SLV       one-hot slave select
//     slv_we_o     out  1           registered write enable
//     slv_addr_o   out  XLEN        word offset inside the selected window
//     slv_wdata_o  out  XLEN        registered write data
//     slv_rdata_i  in   N_SLV*XLEN  slave k read data at [k*XLEN +: XLEN]
//     slv_ack_i    in   N_SLV       slave k completes its access
//     err_count_o  out  ERR_CNT_W   saturating count of failed accesses
// -----------------------------------------------------------------------------
import bus_pkg::*;

module data_bus_interconnect #(
  parameter int XLEN        = 32,
  parameter int N_SLV       = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [XLEN-1:0]       cpu_addr_i,
  input  logic [XLEN-1:0]       cpu_wdata_i,
  output logic [XLEN-1:0]       cpu_rdata_o,
  output logic                  cpu_ready_o,
  output logic                  cpu_err_o,
  output logic [N_SLV-1:0]      slv_sel_o,
  output logic                  slv_we_o,
  output logic [XLEN-1:0]       slv_addr_o,
  output logic [XLEN-1:0]       slv_wdata_o,
  input  logic [N_SLV*XLEN-1:0] slv_rdata_i,
  input  logic [N_SLV-1:0]      slv_ack_i,
  output logic [ERR_CNT_W-1:0]  err_count_o
);

  localparam int IDX_W = idx_width(N_SLV);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  // Decoder view of the incoming request.
  logic             dec_hit;
  logic [N_SLV-1:0] dec_sel;
  logic [IDX_W-1:0] dec_idx;
  logic [XLEN-1:0]  dec_off;
  logic             misaligned;

  bus_addr_decoder #(
    .XLEN  (XLEN),
    .N_SLV (N_SLV),
    .IDX_W (IDX_W)
  ) u_dec (
    .addr   (cpu_addr_i),
    .hit    (dec_hit),
    .sel    (dec_sel),
    .index  (dec_idx),
    .offset (dec_off)
  );

  assign misaligned = |cpu_addr_i[1:0];

  // State and datapath registers.
  bus_state_t           state_reg,   state_next;
  logic [N_SLV-1:0]     sel_reg,     sel_next;
  logic                 we_reg,      we_next;
  logic [XLEN-1:0]      addr_reg,    addr_next;
  logic [XLEN-1:0]      wdata_reg,   wdata_next;
  logic [IDX_W-1:0]     idx_reg,     idx_next;
  logic [TMO_W-1:0]     tmo_reg,     tmo_next;
  logic [XLEN-1:0]      rdata_reg,   rdata_next;
  logic                 ready_reg,   ready_next;
  logic                 err_reg,     err_next;
  logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;

  logic            log_err;
  logic [XLEN-1:0] sel_rdata;

  assign sel_rdata = slv_rdata_i[int'(idx_reg) * XLEN +: XLEN];

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    idx_next     = idx_reg;
    tmo_next     = tmo_reg;
    rdata_next   = rdata_reg;
    ready_next   = 1'b0;
    err_next     = 1'b0;
    err_cnt_next = err_cnt_reg;
    log_err      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cpu_req_i) begin
          if (misaligned || !dec_hit) begin
            // Reject at once. No slave ever sees this access.
            state_next = RESP;
            ready_next = 1'b1;
            err_next   = 1'b1;
            rdata_next = XLEN'(ERR_RDATA);
            log_err    = 1'b1;
          end else begin
            state_next = ACCESS;
            sel_next   = dec_sel;
            we_next    = cpu_we_i;
            addr_next  = dec_off;
            wdata_next = cpu_wdata_i;
            idx_next   = dec_idx;
            tmo_next   = '0;
          end
        end
      end

      ACCESS: begin
        // An ack wins over a timeout that expires in the same cycle.
        if (slv_ack_i[idx_reg]) begin
          state_next = RESP;
          sel_next   = '0;
          ready_next = 1'b1;
          // Only reads update the returned data. A write ack leaves the
          // last read value in place.
          if (!we_reg) begin
            rdata_next = sel_rdata;
          end
        end else if (tmo_reg == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_next = RESP;
          sel_next   = '0;
          ready_next = 1'b1;
          err_next   = 1'b1;
          rdata_next = XLEN'(ERR_RDATA);
          log_err    = 1'b1;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end

      RESP: begin
        // Any request seen here is ignored. It is sampled again in IDLE.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        sel_next   = '0;
      end
    endcase

    if (log_err && (err_cnt_reg != '1)) begin
      err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      sel_reg     <= '0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      idx_reg     <= '0;
      tmo_reg     <= '0;
      rdata_reg   <= '0;
      ready_reg   <= 1'b0;
      err_reg     <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      idx_reg     <= idx_next;
      tmo_reg     <= tmo_next;
      rdata_reg   <= rdata_next;
      ready_reg   <= ready_next;
      err_reg     <= err_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

  assign cpu_rdata_o = rdata_reg;
  assign cpu_ready_o = ready_reg;
  assign cpu_err_o   = err_reg;
  assign slv_sel_o   = sel_reg;
  assign slv_we_o    = we_reg;
  assign slv_addr_o  = addr_reg;
  assign slv_wdata_o = wdata_reg;
  assign err_count_o = err_cnt_reg;

endmodule
